// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
//   muldiv_op_t    : operation encoding on the op port
//   muldiv_state_t : control FSM states
//   cond_neg       : conditional two's-complement negate, used both to take
//                    operand magnitudes and to restore result signs
package muldiv_pkg;

  // Widest value cond_neg handles; covers the 2*WIDTH product for WIDTH <= 64.
  localparam int MD_MAX_W = 128;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } muldiv_state_t;

  // Callers zero-extend into MD_MAX_W and cast the result back to their width;
  // the low bits of the wide negate equal the narrow negate.
  function automatic logic [MD_MAX_W-1:0] cond_neg(input logic [MD_MAX_W-1:0] value,
                                                   input logic                neg);
    return neg ? ((~value) + MD_MAX_W'(1)) : value;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, fixed latency:
// start edge N, results and done pulse after edge N+WIDTH+1.
// Ports:
//   Clk, reset     : clock (rising edge), async active-low reset
//   start, op      : one-cycle launch, sampled in IDLE (00 MULTU,01 MULT,10 DIVU,11 DIV)
//   lhs, rhs       : multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we   : MTHI/MTLO write enables (only while not busy), data on wdata
//   busy, done     : operation in progress / one-cycle completion pulse
//   div_by_zero    : set by the last divide when its divisor was zero
//   hi, lo         : HI/LO architectural registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32  // must be between 4 and 64
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t state, state_nxt;
  muldiv_op_t    op_in;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, acc_nxt;   // mult: {product_hi, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]     opnd;           // |multiplicand| or |divisor|
  logic [WIDTH-1:0]     lhs_raw;        // untouched dividend for the divide-by-zero result
  logic                 is_div, neg_q, neg_r, zero_div;

  logic                 signed_op, lhs_neg, rhs_neg;
  logic [WIDTH-1:0]     lhs_abs, rhs_abs;
  logic [WIDTH+1:0]     add_a, add_b, add_s;
  logic                 add_cin;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign op_in     = muldiv_op_t'(op);
  assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign lhs_neg   = signed_op & lhs[WIDTH-1];
  assign rhs_neg   = signed_op & rhs[WIDTH-1];
  assign lhs_abs   = WIDTH'(cond_neg(MD_MAX_W'(lhs), lhs_neg));
  assign rhs_abs   = WIDTH'(cond_neg(MD_MAX_W'(rhs), rhs_neg));

  assign busy = (state != S_IDLE);

  // Shared adder. Divide trial-subtracts from the top WIDTH+1 bits of the
  // left-shifted {rem,quot}: the partial remainder can briefly need WIDTH+1
  // bits, and the extra MSB gives the borrow (negative result) flag.
  always_comb begin
    add_a   = {2'b00, acc[2*WIDTH-1:WIDTH]};
    add_b   = {2'b00, opnd};
    add_cin = 1'b0;
    if (is_div) begin
      add_a   = {1'b0, acc[2*WIDTH-1:WIDTH-1]};
      add_b   = ~{2'b00, opnd};
      add_cin = 1'b1;
    end
    add_s = add_a + add_b + {{(WIDTH+1){1'b0}}, add_cin};
  end

  always_comb begin
    acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    if (!is_div) begin
      if (acc[0]) acc_nxt = {add_s[WIDTH:0], acc[WIDTH-1:1]};
    end else if (add_s[WIDTH+1]) begin
      acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {add_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign restoration applied in FIX.
  assign prod_fix = (2*WIDTH)'(cond_neg(MD_MAX_W'(acc), neg_q));
  assign quo_fix  = WIDTH'(cond_neg(MD_MAX_W'(acc[WIDTH-1:0]), neg_q));
  assign rem_fix  = WIDTH'(cond_neg(MD_MAX_W'(acc[2*WIDTH-1:WIDTH]), neg_r));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == CW'(WIDTH-1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      lhs_raw     <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // An MTHI/MTLO alongside an accepted start lands now; FIX overwrites it.
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div      <= op[1];
            acc         <= {{WIDTH{1'b0}}, (op[1] ? lhs_abs : rhs_abs)};
            opnd        <= op[1] ? rhs_abs : lhs_abs;
            lhs_raw     <= lhs;
            neg_q       <= lhs_neg ^ rhs_neg;
            neg_r       <= lhs_neg;
            zero_div    <= (rhs == '0);
            div_by_zero <= 1'b0;
            cnt         <= '0;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          done <= 1'b1;
          if (is_div && zero_div) begin
            div_by_zero <= 1'b1;
            hi          <= lhs_raw;
            lo          <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32): vector table plus hand sequences
// for MTHI/MTLO, ignored starts, back-to-back start on done, and mid-run reset.
module tb_muldiv_unit;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] lhs = '0, rhs = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op), .lhs(lhs), .rhs(rhs),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after the edge that sampled start; counts edges until done.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = busy;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    @(negedge Clk);
    op = o; lhs = a; rhs = b; start = 1'b1;
    @(posedge Clk); #1;
    // Scramble inputs: the unit must work from its latched copies.
    start = 1'b0; op = ~o; lhs = ~a; rhs = '0;
    wait_done(lat, busy_ok);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit bok;
    int bad;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b0};
    vecs[11] = '{2'b01, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0};

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge Clk); reset = 1'b1;

    // MTHI / MTLO while idle
    @(negedge Clk); hi_we = 1'b1; wdata = 32'h1234;
    @(posedge Clk); #1; hi_we = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_hold", lo, 0);
    @(negedge Clk); lo_we = 1'b1; wdata = 32'h5678;
    @(posedge Clk); #1; lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi_hold", hi, 32'h1234);

    // MTHI together with an accepted start: write lands, FIX overwrites it
    @(negedge Clk); op = 2'b00; lhs = 32'd6; rhs = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'hABCD;
    @(posedge Clk); #1; start = 1'b0; hi_we = 1'b0;
    check("we_start_hi", hi, 32'hABCD);
    check("we_start_busy", 32'(busy), 1);
    wait_done(lat, bok);
    check("we_start_lat", 32'(lat), 33);
    check("we_start_res_hi", hi, 0);
    check("we_start_res_lo", lo, 32'd42);

    // MTLO and a second start while busy are both ignored
    @(negedge Clk); op = 2'b00; lhs = 32'd3; rhs = 32'd5; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge Clk);
    @(negedge Clk); start = 1'b1; op = 2'b10; lhs = 32'd100; rhs = 32'd7; lo_we = 1'b1; wdata = 32'hDEAD;
    @(posedge Clk); #1; start = 1'b0; lo_we = 1'b0;
    check("busy_mtlo_lo", lo, 32'd42);
    wait_done(lat, bok);
    check("busy_start_lat", 32'(lat), 28);
    check("busy_start_busy", 32'(bok), 1);
    check("busy_start_hi", hi, 0);
    check("busy_start_lo", lo, 32'd15);

    // New start issued in the done cycle is accepted
    check("b2b_done_high", 32'(done), 1);
    op = 2'b10; lhs = 32'd100; rhs = 32'd7; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    wait_done(lat, bok);
    check("b2b_lat", 32'(lat), 33);
    check("b2b_hi", hi, 32'd2);
    check("b2b_lo", lo, 32'd14);

    // Vector table
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      check($sformatf("v%0d_lat", i), 32'(lat), 33);
      check($sformatf("v%0d_busy", i), 32'(bok), 1);
      check($sformatf("v%0d_busy_end", i), 32'(busy), 0);
      @(posedge Clk); #1;
      check($sformatf("v%0d_done_pulse", i), 32'(done), 0);
    end

    // Reset mid-run aborts with no done
    @(negedge Clk); op = 2'b01; lhs = 32'hFFFFFFFD; rhs = 32'd7; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge Clk);
    #2; reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", 32'(done), 0);
    @(negedge Clk); @(negedge Clk); reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (done || busy) bad++;
    end
    check("abort_no_done", 32'(bad), 0);
    do_op(2'b10, 32'd100, 32'd7, lat, bok);
    check("post_rst_lat", 32'(lat), 33);
    check("post_rst_hi", hi, 32'd2);
    check("post_rst_lo", lo, 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers, for the multicycle datapath's MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO support. Control starts an operation with a one-cycle start pulse. It stalls on busy and advances when done pulses. The unit is shift-add for multiply and restoring for divide, handling one bit per cycle, with a fixed, data-independent latency.

Parameters:
WIDTH, 32, operand width and HI/LO register width; must be >= 4.

Ports:
Clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin operation; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
lhs  in  WIDTH  multiplicand / dividend (register A)
rhs  in  WIDTH  multiplier / divisor (register B)
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse; HI/LO valid
div_by_zero  out  1  sticky flag for the last operation; valid with done
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0, internal regs=0. Applies at any time, including mid-operation; no done is produced for an aborted operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - If start=1 at edge N, latch op.
  - Latch |lhs| and |rhs|; absolute value only for signed ops. Latch the result sign (mult: sign(lhs) XOR sign(rhs); div quotient: same; div remainder: sign(lhs)).
  - Clear div_by_zero, set counter=0, go to RUN, busy=1.
- RUN, WIDTH cycles with counter 0..WIDTH-1:
  - Multiply: if the current multiplier bit is 1, add the multiplicand into the upper half of a 2*WIDTH product, then shift right by 1.
  - Divide: shift {rem,quot} left by 1 and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
  - When counter=WIDTH-1, go to FIX.
- FIX, one cycle, at edge N+WIDTH+1:
  - Apply sign correction (two's-complement negate where the sign flag is set).
  - Mult: hi=product[2W-1:W], lo=product[W-1:0].
  - Div: lo=quotient, hi=remainder.
  - Set done=1 for exactly the cycle following this edge, busy=0, and return to IDLE.
- Latency: start edge N; hi/lo are updated and done=1 in the cycle after edge N+WIDTH+1. That is WIDTH+1 edges, independent of the data.
- Divide by zero (rhs=0, DIVU or DIV):
  - Still takes the full latency.
  - div_by_zero=1, hi=lhs (original, unsigned-untouched), lo=all ones. No sign correction.
- Signed overflow, DIV of MIN by -1: lo=MIN, hi=0 (natural wrap), div_by_zero=0.
- Signed remainder takes the dividend's sign; the quotient truncates toward zero.
- start while busy: ignored; no queueing. start and done in the same cycle: the unit is in IDLE, so the new operation is accepted.
- hi_we/lo_we:
  - Honoured only when busy=0; write wdata on the edge.
  - Simultaneous with an accepted start: the write takes effect, and FIX later overwrites it.
  - Ignored while busy.
- hi/lo hold their value otherwise. MFHI/MFLO read them directly.
- op changes after start have no effect.

Decomposition:
- Package muldiv_pkg:
  - muldiv_op_t enum (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV).
  - muldiv_state_t enum (S_IDLE, S_RUN, S_FIX).
  - Function cond_neg(value, neg) for sign conversion/correction.
- No sub-module required. Multiply and divide share one 2*WIDTH accumulator and one WIDTH+1 adder/subtractor inside muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF (WIDTH=32) -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after start edge; busy high throughout.
- MULT lhs=-3 (0xFFFFFFFD), rhs=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV lhs=-7, rhs=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU 100/0 -> div_by_zero=1, hi=100, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- MTHI 0x1234 while idle -> hi=0x1234 next cycle. MTLO while busy -> lo unchanged. Second start at RUN cycle 5 -> ignored; the first result is unaffected.
- Drop reset at RUN cycle 10 -> immediately busy=0, hi=lo=0, no done. A start after reset release -> normal operation with the same latency.
